// File: rtl/fpu_pkg.sv
// Shared floating-point constants and operand classification for the FPU
// issue controllers (adder/subtractor and multiplier).
package fpu_pkg;

  localparam logic [31:0] QNAN     = 32'h7FC00000;
  localparam logic [7:0]  EXP_ONES = 8'hFF;
  localparam logic [31:0] POS_INF  = 32'h7F800000;
  localparam logic [31:0] NEG_INF  = 32'hFF800000;

  typedef enum logic [2:0] {
    ZERO,
    SUBN,
    NORM,
    INF,
    QNAN_C,
    SNAN
  } fp_class_e;

  // IEEE-754 single classification; bit 22 separates quiet from signalling NaN.
  function automatic fp_class_e fp_classify(input logic [31:0] x);
    logic [7:0]  exp_f;
    logic [22:0] mant_f;
    exp_f  = x[30:23];
    mant_f = x[22:0];
    if (exp_f == EXP_ONES) begin
      if (mant_f == 23'd0)  return INF;
      else if (mant_f[22])  return QNAN_C;
      else                  return SNAN;
    end else if (exp_f == 8'd0) begin
      if (mant_f == 23'd0)  return ZERO;
      else                  return SUBN;
    end
    return NORM;
  endfunction

endpackage

// File: rtl/fp_special_detect.sv
// Combinational NaN/Inf resolution for an add/subtract. B's sign is taken
// after the subtract flip so Inf-Inf cancellation is judged on effective signs.
module fp_special_detect #(
  parameter logic [31:0] QNAN = fpu_pkg::QNAN
) (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        sub,
  output logic        special,
  output logic [31:0] spec_val,
  output logic        nv
);
  import fpu_pkg::*;

  fp_class_e ca;
  fp_class_e cb;
  logic      sa;
  logic      sb;
  logic      a_nan;
  logic      b_nan;

  // Classify both operands and pick the bypass value, NaN taking priority over Inf.
  always_comb begin
    ca       = fp_classify(a);
    cb       = fp_classify(b);
    sa       = a[31];
    sb       = b[31] ^ sub;
    a_nan    = (ca == QNAN_C) || (ca == SNAN);
    b_nan    = (cb == QNAN_C) || (cb == SNAN);
    special  = 1'b0;
    spec_val = QNAN;
    nv       = 1'b0;
    if (a_nan || b_nan) begin
      special  = 1'b1;
      spec_val = QNAN;
      nv       = (ca == SNAN) || (cb == SNAN);
    end else if ((ca == INF) && (cb == INF)) begin
      special = 1'b1;
      if (sa != sb) begin
        spec_val = QNAN;
        nv       = 1'b1;
      end else begin
        spec_val = sa ? NEG_INF : POS_INF;
      end
    end else if (ca == INF) begin
      special  = 1'b1;
      spec_val = sa ? NEG_INF : POS_INF;
    end else if (cb == INF) begin
      special  = 1'b1;
      spec_val = sb ? NEG_INF : POS_INF;
    end
  end

endmodule

// File: rtl/fpu_addsub_ctrl.sv
// Issue/sequencing controller for the single-precision add/sub datapath.
// Registers operands toward the datapath, carries a valid bit and the
// special-case bypass alongside each in-flight operation, and holds the final
// result in an output register that stalls the whole pipe under backpressure.
module fpu_addsub_ctrl #(
  parameter int          LATENCY = 3,
  parameter logic [31:0] QNAN    = fpu_pkg::QNAN
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_a,
  input  logic [31:0] in_b,
  input  logic        in_sub,
  input  logic        flush,
  output logic [31:0] dp_a,
  output logic [31:0] dp_b,
  output logic        dp_a_s,
  output logic        dp_enable,
  output logic        dp_ce,
  input  logic [31:0] dp_result,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_result,
  output logic        out_nv,
  output logic        busy
);
  import fpu_pkg::*;

  logic               stall;
  logic               accept;
  logic               det_special;
  logic [31:0]        det_val;
  logic               det_nv;

  logic [31:0]        dp_a_q, dp_a_d;
  logic [31:0]        dp_b_q, dp_b_d;
  logic               dp_a_s_q, dp_a_s_d;
  logic               dp_enable_q, dp_enable_d;
  logic [LATENCY-1:0] v_q, v_d;
  logic [LATENCY-1:0] spec_flag_q, spec_flag_d;
  logic [LATENCY-1:0] nv_q, nv_d;
  logic [31:0]        spec_val_q [LATENCY];
  logic [31:0]        spec_val_d [LATENCY];
  logic               out_valid_q, out_valid_d;
  logic [31:0]        out_result_q, out_result_d;
  logic               out_nv_q, out_nv_d;

  fp_special_detect #(
    .QNAN (QNAN)
  ) u_detect (
    .a        (in_a),
    .b        (in_b),
    .sub      (in_sub),
    .special  (det_special),
    .spec_val (det_val),
    .nv       (det_nv)
  );

  // A full output register with no taker freezes every stage, datapath included.
  assign stall    = out_valid_q & ~out_ready;
  assign in_ready = ~stall;
  assign dp_ce    = ~stall;
  // A request arriving together with flush is dropped, not issued.
  assign accept   = in_valid & ~stall & ~flush;

  // Next-state: hold when stalled, otherwise shift the tracking pipe and load the output.
  always_comb begin
    dp_a_d       = dp_a_q;
    dp_b_d       = dp_b_q;
    dp_a_s_d     = dp_a_s_q;
    dp_enable_d  = dp_enable_q;
    v_d          = v_q;
    spec_flag_d  = spec_flag_q;
    nv_d         = nv_q;
    for (int k = 0; k < LATENCY; k++) spec_val_d[k] = spec_val_q[k];
    out_valid_d  = out_valid_q;
    out_result_d = out_result_q;
    out_nv_d     = out_nv_q;

    if (!stall) begin
      dp_enable_d = 1'b0;
      if (accept) begin
        dp_a_d      = in_a;
        dp_b_d      = in_b;
        dp_a_s_d    = in_sub;
        dp_enable_d = ~det_special;
      end
      v_d[0]         = accept;
      spec_flag_d[0] = accept & det_special;
      nv_d[0]        = accept & det_nv;
      spec_val_d[0]  = det_val;
      for (int k = 1; k < LATENCY; k++) begin
        v_d[k]         = v_q[k-1];
        spec_flag_d[k] = spec_flag_q[k-1];
        nv_d[k]        = nv_q[k-1];
        spec_val_d[k]  = spec_val_q[k-1];
      end
      out_valid_d  = v_q[LATENCY-1];
      out_result_d = spec_flag_q[LATENCY-1] ? spec_val_q[LATENCY-1] : dp_result;
      out_nv_d     = nv_q[LATENCY-1];
    end

    if (flush) begin
      v_d         = '0;
      spec_flag_d = '0;
      out_valid_d = 1'b0;
    end
  end

  // Control and architecturally visible registers, cleared by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      dp_a_q       <= 32'd0;
      dp_b_q       <= 32'd0;
      dp_a_s_q     <= 1'b0;
      dp_enable_q  <= 1'b0;
      v_q          <= '0;
      spec_flag_q  <= '0;
      nv_q         <= '0;
      out_valid_q  <= 1'b0;
      out_result_q <= 32'd0;
      out_nv_q     <= 1'b0;
    end else begin
      dp_a_q       <= dp_a_d;
      dp_b_q       <= dp_b_d;
      dp_a_s_q     <= dp_a_s_d;
      dp_enable_q  <= dp_enable_d;
      v_q          <= v_d;
      spec_flag_q  <= spec_flag_d;
      nv_q         <= nv_d;
      out_valid_q  <= out_valid_d;
      out_result_q <= out_result_d;
      out_nv_q     <= out_nv_d;
    end
  end

  // Bypass values are only consumed under a set spec_flag, so they skip reset.
  always_ff @(posedge clk) begin
    for (int k = 0; k < LATENCY; k++) spec_val_q[k] <= spec_val_d[k];
  end

  assign dp_a       = dp_a_q;
  assign dp_b       = dp_b_q;
  assign dp_a_s     = dp_a_s_q;
  assign dp_enable  = dp_enable_q;
  assign out_valid  = out_valid_q;
  assign out_result = out_result_q;
  assign out_nv     = out_nv_q;
  assign busy       = (|v_q) | out_valid_q;

endmodule
